// File: rtl/jk_cmd_sequencer_if.sv
// Command/status bundle for jk_cmd_sequencer; the abort line exists only with JK_SEQ_ABORT_EN.
interface jk_cmd_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_count;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       busy;
  logic       done;
  logic [2:0] fifo_level;
`ifdef JK_SEQ_ABORT_EN
  logic       abort;
`endif

  modport master (
`ifdef JK_SEQ_ABORT_EN
    output abort,
`endif
    output cmd_valid, cmd_op, cmd_count,
    input  cmd_ready, j, k, busy, done, fifo_level
  );

  modport slave (
`ifdef JK_SEQ_ABORT_EN
    input  abort,
`endif
    input  cmd_valid, cmd_op, cmd_count,
    output cmd_ready, j, k, busy, done, fifo_level
  );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// JK command sequencer: 4-deep {op,count} FIFO drives registered j/k for count+1 cycles, 1-cycle push-to-drive latency.
// Backpressure: cmd_ready low while 4 entries are held; optional abort input under JK_SEQ_ABORT_EN.
module jk_cmd_sequencer (
  input  logic              clk,
  input  logic              reset,
  jk_cmd_sequencer_if.slave bus
);
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] count;
  } cmd_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  cmd_t       mem [4];
  cmd_t       head;
  cmd_t       wr_dat;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] level;
  logic [1:0] op, op_nxt;
  logic [3:0] rem, rem_nxt;
  logic       j_q, k_q, j_nxt, k_nxt;
  logic       push, pop, flush;

  assign head          = mem[rd_ptr];
  assign wr_dat        = {bus.cmd_op, bus.cmd_count};
  assign bus.cmd_ready = (level != 3'd4);
`ifdef JK_SEQ_ABORT_EN
  assign flush = bus.abort;
`else
  assign flush = 1'b0;
`endif
  // A command offered on a flush edge is dropped rather than queued behind it.
  assign push  = bus.cmd_valid && bus.cmd_ready && !flush;

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    rem_nxt   = rem;
    j_nxt     = j_q;
    k_nxt     = k_q;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      j_nxt     = 1'b0;
      k_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (level != 3'd0) begin
            pop       = 1'b1;
            state_nxt = RUN;
            op_nxt    = head.op;
            rem_nxt   = head.count;
            j_nxt     = head.op[1];
            k_nxt     = head.op[0];
          end
        end
        RUN: begin
          if (rem != 4'd0) begin
            rem_nxt = rem - 4'd1;
          end else if (level != 3'd0) begin
            // Reload straight from the FIFO so back-to-back commands leave no idle gap.
            pop     = 1'b1;
            op_nxt  = head.op;
            rem_nxt = head.count;
            j_nxt   = head.op[1];
            k_nxt   = head.op[0];
          end else begin
            state_nxt = IDLE;
            j_nxt     = 1'b0;
            k_nxt     = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op     <= 2'd0;
      rem    <= 4'd0;
      j_q    <= 1'b0;
      k_q    <= 1'b0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      level  <= 3'd0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      rem   <= rem_nxt;
      j_q   <= j_nxt;
      k_q   <= k_nxt;
      if (flush) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
        level  <= 3'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        if (push && !pop)      level <= level + 3'd1;
        else if (pop && !push) level <= level - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= wr_dat;
  end

  assign bus.j          = j_q;
  assign bus.k          = k_q;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == RUN) && (rem == 4'd0);
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized self-checking bench for jk_cmd_sequencer against a queue-based command model.
module tb_jk_cmd_sequencer;
  logic clk = 1'b0;
  logic reset;
  jk_cmd_sequencer_if bus();

  jk_cmd_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending commands, and the running one with cycles still to drive (incl. current).
  logic [5:0] m_q[$];
  bit         m_active;
  logic [1:0] m_op;
  int         m_left;
  logic       dq;
  int         toggles;
  logic [1:0] jk_prev;

  logic [8:0] observed;
  assign observed = {bus.j, bus.k, bus.busy, bus.done, bus.cmd_ready, bus.fifo_level};

  function automatic logic [8:0] expected();
    logic [2:0] lvl;
    lvl = 3'(m_q.size());
    return {m_active & m_op[1], m_active & m_op[0], m_active, m_active && (m_left == 1),
            lvl != 3'd4, lvl};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] cnt);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
  endtask

  task automatic cycle();
    logic [5:0] hd;
    bit         acc;
    bit         do_flush;
    jk_prev = {bus.j, bus.k};
    @(posedge clk);
    do_flush = reset;
`ifdef JK_SEQ_ABORT_EN
    do_flush = do_flush | bus.abort;
`endif
    if (do_flush) begin
      m_q.delete();
      m_active = 1'b0;
    end else begin
      acc = bus.cmd_valid && (m_q.size() < 4);
      if (m_active && m_left > 1) begin
        m_left--;
      end else if (m_q.size() > 0) begin
        hd       = m_q.pop_front();
        m_op     = hd[5:4];
        m_left   = int'(hd[3:0]) + 1;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
      if (acc) m_q.push_back({bus.cmd_op, bus.cmd_count});
    end
    case (jk_prev)
      2'b01: dq = 1'b0;
      2'b10: dq = 1'b1;
      2'b11: begin dq = ~dq; toggles++; end
      default: ;
    endcase
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    drive(1'b0, 2'b00, 4'd0);
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 2'b11, 4'hF);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL reset cyc%0d: got %b want %b", i, observed, expected());
      end
    end
    checks++;
    if (observed !== 9'b000_0_1_000) begin
      errors++; $display("FAIL reset_state: got %b want 000010000", observed);
    end
    reset = 1'b0;
    drive(1'b0, 2'b00, 4'd0);
  endtask

  task automatic test_single();
    drive(1'b1, 2'b10, 4'd2);
    for (int e = 1; e <= 6; e++) begin
      cycle();
      drive(1'b0, 2'b00, 4'd0);
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL single e%0d: got %b want %b", e, observed, expected());
      end
      if (e >= 2 && e <= 4) begin
        checks++;
        if ({bus.j, bus.k} !== 2'b10) begin
          errors++; $display("FAIL single_jk e%0d: got %b want 10", e, {bus.j, bus.k});
        end
      end
      if (e == 4) begin
        checks++;
        if (bus.done !== 1'b1) begin
          errors++; $display("FAIL single_done: got %b want 1", bus.done);
        end
      end
      if (e == 5) begin
        checks++;
        if ({bus.j, bus.k, bus.busy} !== 3'b000) begin
          errors++; $display("FAIL single_end: got %b want 000", {bus.j, bus.k, bus.busy});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b11; exp_seq[2] = 2'b11;
    pulse_reset();
    dq = 1'b1;
    drive(1'b1, 2'b01, 4'd0);
    cycle();
    drive(1'b1, 2'b11, 4'd1);
    toggles = 0;
    for (int e = 2; e <= 6; e++) begin
      cycle();
      drive(1'b0, 2'b00, 4'd0);
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL b2b e%0d: got %b want %b", e, observed, expected());
      end
      if (e <= 4) begin
        checks++;
        if ({bus.j, bus.k} !== exp_seq[e-2]) begin
          errors++; $display("FAIL b2b_jk e%0d: got %b want %b", e, {bus.j, bus.k}, exp_seq[e-2]);
        end
      end
    end
    checks++;
    if (toggles !== 2 || dq !== 1'b0) begin
      errors++; $display("FAIL b2b_q: toggles %0d q %b want 2 and 0", toggles, dq);
    end
  endtask

  task automatic test_full();
    logic [5:0] pushed [4];
    logic [1:0] exp_jk[$];
    logic [1:0] got_jk[$];
    logic [1:0] op;
    logic [3:0] cnt;
    bit         started;
    int         n;
    pulse_reset();
    drive(1'b1, 2'b11, 4'd15);
    cycle();
    drive(1'b0, 2'b00, 4'd0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      op  = 2'($urandom_range(0, 3));
      cnt = 4'($urandom_range(0, 2));
      drive(1'b1, op, cnt);
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL full push%0d: got %b want %b", i, observed, expected());
      end
      if (i < 4) pushed[i] = {op, cnt};
      if (i >= 3) begin
        checks++;
        if (bus.fifo_level !== 3'd4 || bus.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL full_level push%0d: got lvl %0d rdy %b want 4 0", i, bus.fifo_level, bus.cmd_ready);
        end
      end
    end
    drive(1'b0, 2'b00, 4'd0);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c <= int'(pushed[i][3:0]); c++) exp_jk.push_back(pushed[i][5:4]);
    started = 1'b0;
    n = 0;
    while ((bus.busy || bus.fifo_level != 3'd0) && n < 100) begin
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL full drain%0d: got %b want %b", n, observed, expected());
      end
      if (started && bus.busy) got_jk.push_back({bus.j, bus.k});
      if (!started && bus.done) started = 1'b1;
      n++;
    end
    checks++;
    if (n >= 100 || got_jk.size() != exp_jk.size()) begin
      errors++; $display("FAIL full_order_len: got %0d cycles want %0d", got_jk.size(), exp_jk.size());
    end else begin
      for (int i = 0; i < exp_jk.size(); i++) begin
        checks++;
        if (got_jk[i] !== exp_jk[i]) begin
          errors++; $display("FAIL full_order[%0d]: got %b want %b", i, got_jk[i], exp_jk[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    pulse_reset();
    drive(1'b1, 2'b11, 4'd9);
    cycle();
    drive(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    cycle();
    drive(1'b0, 2'b00, 4'd0);
    n = 0;
    while (m_left != 6 && n < 20) begin
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL midrst run%0d: got %b want %b", n, observed, expected());
      end
      n++;
    end
    if (n >= 20) begin
      errors++; $display("FAIL midrst_timeout: got %0d cycles want <20", n);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if ({bus.j, bus.k, bus.busy, bus.fifo_level} !== 6'b0) begin
      errors++; $display("FAIL midrst_clear: got %b want 000000", {bus.j, bus.k, bus.busy, bus.fifo_level});
    end
    drive(1'b1, 2'b10, 4'd1);
    cycle();
    drive(1'b0, 2'b00, 4'd0);
    checks++;
    if (bus.fifo_level !== 3'd1) begin
      errors++; $display("FAIL midrst_accept: got lvl %0d want 1", bus.fifo_level);
    end
    cycle();
    checks++;
    if ({bus.j, bus.k, bus.busy} !== 3'b101) begin
      errors++; $display("FAIL midrst_start: got %b want 101", {bus.j, bus.k, bus.busy});
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL midrst tail%0d: got %b want %b", i, observed, expected());
      end
    end
  endtask

  task automatic test_simul();
    logic [1:0] bop;
    logic [5:0] cmds [4];
    int n;
    pulse_reset();
    bop     = 2'($urandom_range(0, 3));
    cmds[0] = {~bop, 4'd1};
    cmds[1] = {bop, 4'($urandom_range(0, 3))};
    cmds[2] = 6'($urandom_range(0, 63));
    cmds[3] = 6'($urandom_range(0, 63));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, cmds[i][5:4], cmds[i][3:0]);
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL simul e%0d: got %b want %b", i + 1, observed, expected());
      end
    end
    drive(1'b0, 2'b00, 4'd0);
    checks++;
    if (bus.fifo_level !== 3'd2 || {bus.j, bus.k} !== bop) begin
      errors++; $display("FAIL simul_pushpop: got lvl %0d jk %b want 2 %b", bus.fifo_level, {bus.j, bus.k}, bop);
    end
    n = 0;
    while ((bus.busy || bus.fifo_level != 3'd0) && n < 80) begin
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL simul drain%0d: got %b want %b", n, observed, expected());
      end
      n++;
    end
    if (n >= 80) begin
      errors++; $display("FAIL simul_timeout: got %0d cycles want <80", n);
    end
  endtask

`ifdef JK_SEQ_ABORT_EN
  task automatic test_abort();
    pulse_reset();
    drive(1'b1, 2'b11, 4'd10);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      cycle();
    end
    checks++;
    if (bus.fifo_level !== 3'd3 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_setup: got lvl %0d busy %b want 3 1", bus.fifo_level, bus.busy);
    end
    drive(1'b1, 2'b10, 4'd0);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    drive(1'b0, 2'b00, 4'd0);
    checks++;
    if ({bus.j, bus.k, bus.busy, bus.fifo_level} !== 6'b0) begin
      errors++; $display("FAIL abort_flush: got %b want 000000", {bus.j, bus.k, bus.busy, bus.fifo_level});
    end
    cycle();
    checks++;
    if (observed !== expected()) begin
      errors++; $display("FAIL abort_after: got %b want %b", observed, expected());
    end
    drive(1'b1, 2'b01, 4'd5);
    cycle();
    drive(1'b1, 2'b10, 4'd3);
    cycle();
    drive(1'b0, 2'b00, 4'd0);
    reset = 1'b1;
    bus.abort = 1'b1;
    cycle();
    reset = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (observed !== 9'b000_0_1_000) begin
      errors++; $display("FAIL abort_reset: got %b want 000010000", observed);
    end
    drive(1'b1, 2'b11, 4'd0);
    cycle();
    drive(1'b0, 2'b00, 4'd0);
    cycle();
    checks++;
    if (observed !== expected()) begin
      errors++; $display("FAIL abort_restart: got %b want %b", observed, expected());
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 63) == 0);
`ifdef JK_SEQ_ABORT_EN
      bus.abort = ($urandom_range(0, 79) == 0);
`endif
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 6)));
      cycle();
      checks++;
      if (observed !== expected()) begin
        errors++; $display("FAIL random cyc%0d: got %b want %b", i, observed, expected());
      end
    end
    reset = 1'b0;
`ifdef JK_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    drive(1'b0, 2'b00, 4'd0);
  endtask

  initial begin
    reset    = 1'b1;
    drive(1'b0, 2'b00, 4'd0);
`ifdef JK_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    m_active = 1'b0;
    m_op     = 2'b00;
    m_left   = 0;
    dq       = 1'b0;
    toggles  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_mid_reset();
    test_simul();
`ifdef JK_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  cmd_valid  in  1  command offered
  cmd_op  in  2  00 hold, 01 clear (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1)
  cmd_count  in  4  extra cycles; command drives j/k for cmd_count+1 cycles
  cmd_ready  out  1  command FIFO not full
  j  out  1  J drive to downstream JK flip-flop, registered
  k  out  1  K drive to downstream JK flip-flop, registered
  busy  out  1  FSM in RUN
  done  out  1  last cycle of current command
  fifo_level  out  3  entries held, 0..4

Function
REQ-003 The block SHALL hold a 4-entry FIFO of {cmd_op, cmd_count}; a command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-004 cmd_ready SHALL equal (fifo_level != 4), combinational from registered state; cmd_valid while full SHALL be ignored, with no overwrite and no level change.
REQ-005 The FSM SHALL have two states:
  IDLE: j=k=0.
  RUN: j/k driven from the current op.
REQ-006 In IDLE with fifo_level>0, the next edge SHALL pop the head, load op and rem=count, set j/k per op and enter RUN.
REQ-007 In RUN with rem>0, each edge SHALL decrement rem and keep j/k unchanged.
REQ-008 In RUN with rem==0, the next edge SHALL do one of the following, with no idle gap when back-to-back:
  pop the next entry and reload op/rem/j/k if the FIFO is non-empty, staying in RUN;
  otherwise go to IDLE with j=k=0.
REQ-009 done SHALL equal (state==RUN && rem==0); busy SHALL equal (state==RUN).
REQ-010 Latency SHALL be one cycle: a command accepted at edge N into an empty IDLE block drives j/k from edge N+1 through edge N+1+cmd_count.
REQ-011 A simultaneous push and pop on one edge SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-012 Read and write pointers SHALL be 2 bits and wrap 3->0; fifo_level SHALL be a separate 3-bit counter.
REQ-013 j and k SHALL never change other than on a rising clk edge.

Reset
REQ-014 On reset=1 at a rising edge, including mid-command, the block SHALL:
  flush the FIFO, with pointers and fifo_level=0;
  enter IDLE;
  set rem=0 and j=0, k=0, busy=0, done=0, cmd_ready=1.
REQ-015 cmd_valid SHALL be ignored on any edge where reset=1.
REQ-016 The first command SHALL be acceptable on the first edge after reset deasserts.

Configuration
REQ-017 With macro JK_SEQ_ABORT_EN defined:
  an input abort (1 bit) SHALL be present;
  abort=1 at an edge SHALL flush the FIFO, enter IDLE and force j=k=0 while keeping other state;
  reset SHALL take priority over abort;
  a cmd_valid on the abort edge SHALL be dropped.
REQ-018 Without JK_SEQ_ABORT_EN, the abort port and its logic SHALL be absent and behaviour SHALL be as REQ-003..REQ-016.

Verification
REQ-019 The bench SHALL cover these scenarios:
  Reset then single command: push op=10, count=2 at edge 1 -> j=1,k=0 for edges 2-4; done=1 during the cycle after edge 4; j=k=0 and busy=0 after edge 5.
  Back-to-back: push op=01/count=0 then op=11/count=1 on consecutive edges -> j/k = 01 for 1 cycle, then 11 for 2 cycles with no 00 gap; downstream q toggles twice.
  Full FIFO: while RUN with count=15, push 5 commands -> fifo_level reaches 4, cmd_ready=0, 5th command dropped; the 4 queued commands execute in order.
  Mid-command reset: reset asserted during rem=5 of op=11 -> next cycle j=k=0, fifo_level=0, busy=0; a command pushed on the next edge starts normally.
  Simultaneous push/pop: level=2 while a command ends and a new push arrives on the same edge -> fifo_level stays 2 and the popped entry is the oldest.
  Abort (JK_SEQ_ABORT_EN): abort=1 with level=3 during RUN -> next cycle IDLE, j=k=0, fifo_level=0; reset+abort together gives reset behaviour.
